// File: rtl/instr_reg_rom.sv
// ---------------------------------------------------------------------------
// instr_reg_rom
//
// Purpose:
//    Read-only instruction memory for the single-cycle RISC-V CPU. Holds a
//    fixed 32-word RV32I test program and returns the word selected by a
//    5-bit word address. The output is registered: a read issued on one
//    rising edge appears on o_q right after that edge, so a new address can
//    be presented every cycle. Reset loads a NOP so that the fetch stage
//    sees a harmless instruction until the first real read.
//
// Ports:
//    i_clk    input   1       system clock, rising-edge active
//    i_rst_n  input   1       synchronous active-low reset (wins over i_en)
//    i_en     input   1       read enable; o_q loads ROM[i_addr] when high
//    i_addr   input   ADDR_W  word address, every value is valid
//    o_q      output  DATA_W  registered instruction word
// ---------------------------------------------------------------------------
module instr_reg_rom #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_en,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [DATA_W-1:0] o_q
);

   // addi x0,x0,0 -- the canonical RV32I no-op, also used as the reset value
   localparam logic [DATA_W-1:0] NOP_INSTR = 32'h0000_0013;

   logic [DATA_W-1:0] w_romData;
   logic [DATA_W-1:0] r_q;

   // The program is a constant lookup table. Anything past the halt loop at
   // word 11 is padded with NOPs, which is what the default branch supplies,
   // so the whole address range decodes without any out-of-range handling.
   always_comb begin
      w_romData = NOP_INSTR;
      case (i_addr)
         5'd0:    w_romData = 32'h0050_0093;   // addi x1,x0,5
         5'd1:    w_romData = 32'h00A0_0113;   // addi x2,x0,10
         5'd2:    w_romData = 32'h0020_81B3;   // add  x3,x1,x2
         5'd3:    w_romData = 32'h4011_0233;   // sub  x4,x2,x1
         5'd4:    w_romData = 32'h0020_F2B3;   // and  x5,x1,x2
         5'd5:    w_romData = 32'h0020_E333;   // or   x6,x1,x2
         5'd6:    w_romData = 32'h0030_2023;   // sw   x3,0(x0)
         5'd7:    w_romData = 32'h0000_2383;   // lw   x7,0(x0)
         5'd8:    w_romData = 32'h0071_8463;   // beq  x3,x7,+8
         5'd9:    w_romData = 32'h0010_0413;   // addi x8,x0,1
         5'd10:   w_romData = 32'h0020_A4B3;   // slt  x9,x1,x2
         5'd11:   w_romData = 32'h0000_006F;   // jal  x0,0 (halt loop)
         default: w_romData = NOP_INSTR;
      endcase
   end

   // Output register. Reset is checked first so that a read requested in the
   // same cycle is discarded and the NOP is loaded instead; with the enable
   // low the previous instruction is simply held.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_q <= NOP_INSTR;
      end else if (i_en) begin
         r_q <= w_romData;
      end
   end

   assign o_q = r_q;

endmodule

// File: tb/tb_instr_reg_rom.sv
// ---------------------------------------------------------------------------
// tb_instr_reg_rom
//
// Purpose:
//    Self-checking bench for instr_reg_rom. Directed sequences cover reset,
//    a full address sweep, hold, back-to-back boundary reads, reset in the
//    middle of a sweep and repeatability across resets; a randomized phase
//    then drives random reset/enable/address combinations. Every cycle the
//    output is compared against a reference built from the program table.
//
// Ports:
//    none (top-level bench)
// ---------------------------------------------------------------------------
module tb_instr_reg_rom;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   logic        clk;
   logic        rstN;
   logic        en;
   logic [4:0]  addr;
   logic [31:0] q;

   // Reference program: what each word address is expected to hold
   logic [31:0] romModel [32];

   // Value the registered output should show after the most recent edge
   logic [31:0] expectedQ;

   int checkCount;
   int failCount;

   instr_reg_rom dut (
      .i_clk   (clk),
      .i_rst_n (rstN),
      .i_en    (en),
      .i_addr  (addr),
      .o_q     (q)
   );

   // Free-running 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports any difference
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %08h, expected %08h", tag, observed, expected);
      end
   endtask

   // Drives one cycle of inputs, lets a rising edge happen, updates the
   // reference with the behavioural rule for that edge and checks o_q.
   // Called while sitting 1 ns after a rising edge.
   task automatic applyStimulus(input string tag, input logic rstIn,
                                input logic enIn, input logic [4:0] addrIn);
      rstN = rstIn;
      en   = enIn;
      addr = addrIn;
      @(posedge clk);
      if (!rstIn)
         expectedQ = NOP_INSTR;
      else if (enIn)
         expectedQ = romModel[addrIn];
      #1;
      checkOutput(tag, q, expectedQ);
   endtask

   // Main sequence
   initial begin
      checkCount = 0;
      failCount  = 0;
      expectedQ  = NOP_INSTR;

      for (int i = 0; i < 32; i++) romModel[i] = NOP_INSTR;
      romModel[0]  = 32'h0050_0093;
      romModel[1]  = 32'h00A0_0113;
      romModel[2]  = 32'h0020_81B3;
      romModel[3]  = 32'h4011_0233;
      romModel[4]  = 32'h0020_F2B3;
      romModel[5]  = 32'h0020_E333;
      romModel[6]  = 32'h0030_2023;
      romModel[7]  = 32'h0000_2383;
      romModel[8]  = 32'h0071_8463;
      romModel[9]  = 32'h0010_0413;
      romModel[10] = 32'h0020_A4B3;
      romModel[11] = 32'h0000_006F;

      rstN = 1'b0;
      en   = 1'b1;
      addr = 5'd3;
      @(posedge clk);
      #1;

      // Reset dominates an active read; release gives word 3 one edge later
      applyStimulus("reset_edge1", 1'b0, 1'b1, 5'd3);
      applyStimulus("reset_edge2", 1'b0, 1'b1, 5'd3);
      checkOutput("reset_nop_const", q, NOP_INSTR);
      applyStimulus("reset_release", 1'b1, 1'b1, 5'd3);
      checkOutput("release_word3", q, 32'h4011_0233);

      // Full sweep, one address per cycle
      for (int a = 0; a < 32; a++)
         applyStimulus($sformatf("sweep_a%0d", a), 1'b1, 1'b1, 5'(a));
      checkOutput("sweep_last_nop", q, 32'h0000_0013);

      // Hold with enable low while the address moves
      applyStimulus("hold_read2", 1'b1, 1'b1, 5'd2);
      for (int c = 0; c < 3; c++)
         applyStimulus($sformatf("hold_c%0d", c), 1'b1, 1'b0, 5'd5);
      checkOutput("hold_value", q, 32'h0020_81B3);
      applyStimulus("hold_resume5", 1'b1, 1'b1, 5'd5);
      checkOutput("resume_word5", q, 32'h0020_E333);

      // Back-to-back alternation between the two ends of the address range
      applyStimulus("b2b_31a", 1'b1, 1'b1, 5'd31);
      applyStimulus("b2b_0a",  1'b1, 1'b1, 5'd0);
      checkOutput("b2b_word0", q, 32'h0050_0093);
      applyStimulus("b2b_31b", 1'b1, 1'b1, 5'd31);
      applyStimulus("b2b_0b",  1'b1, 1'b1, 5'd0);

      // Reset for a single edge in the middle of a sweep
      for (int a = 6; a < 16; a++)
         applyStimulus($sformatf("midrst_a%0d", a), (a != 10), 1'b1, 5'(a));

      // Repeatability after a second reset
      applyStimulus("rep_reset", 1'b0, 1'b0, 5'd0);
      applyStimulus("rep_word6", 1'b1, 1'b1, 5'd6);
      checkOutput("rep_word6_const", q, 32'h0030_2023);
      applyStimulus("rep_word7", 1'b1, 1'b1, 5'd7);
      checkOutput("rep_word7_const", q, 32'h0000_2383);

      // Randomized reset/enable/address traffic
      for (int n = 0; n < 400; n++) begin
         logic rIn;
         logic eIn;
         rIn = ($urandom_range(0, 15) != 0);
         eIn = ($urandom_range(0, 3) != 0);
         applyStimulus($sformatf("rand_%0d", n), rIn, eIn, 5'($urandom_range(0, 31)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule
